// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI responder.
package spi_pkg;

  // SPI mode 0: SCLK idles low, data sampled on the rising edge.
  localparam bit Cpol = 1'b0;
  localparam bit Cpha = 1'b0;

  localparam int unsigned DefaultDataWidth = 8;
  localparam logic [DefaultDataWidth-1:0] DefaultIdleWord = '1;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/spi_slave_responder_if.sv
// SPI pins plus the RX/TX word streams and status pulses of the responder.
interface spi_slave_responder_if import spi_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
);

  logic                  io_spi_sclk;
  logic                  io_spi_ss;
  logic                  io_spi_mosi;
  logic                  io_spi_miso_write;
  logic                  io_spi_miso_writeEnable;
  logic                  io_rx_valid;
  logic                  io_rx_ready;
  logic [DATA_WIDTH-1:0] io_rx_payload;
  logic                  io_tx_valid;
  logic                  io_tx_ready;
  logic [DATA_WIDTH-1:0] io_tx_payload;
  logic                  io_active;
  logic                  io_overrun;
  logic                  io_underrun;

  modport slave (
    input  io_spi_sclk, io_spi_ss, io_spi_mosi, io_rx_ready, io_tx_valid, io_tx_payload,
    output io_spi_miso_write, io_spi_miso_writeEnable, io_rx_valid, io_rx_payload,
           io_tx_ready, io_active, io_overrun, io_underrun
  );

  modport master (
    output io_spi_sclk, io_spi_ss, io_spi_mosi, io_rx_ready, io_tx_valid, io_tx_payload,
    input  io_spi_miso_write, io_spi_miso_writeEnable, io_rx_valid, io_rx_payload,
           io_tx_ready, io_active, io_overrun, io_underrun
  );

endinterface

// File: rtl/spi_sync_vec.sv
// Multi-stage synchronizer for a vector of asynchronous pins, with edge detection
// against one extra delay flop behind the last stage.
module spi_sync_vec #(
  parameter int unsigned Width  = 3,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  // Index 0 is the first (newest) stage.
  logic [Stages-1:0][Width-1:0] sync_q;
  logic [Width-1:0]             dly_q;

  // Shift the pins through the synchronizer chain and the edge-detect delay flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      dly_q  <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~dly_q;
  assign fall_o = ~sync_q[Stages-1] & dly_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled pins, RX words out on a valid/ready stream,
// TX words from a single-entry holding register fed by a second stream.
module spi_slave_responder import spi_pkg::*; #(
  parameter int unsigned         DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = '1
) (
  input logic                  io_sys_clock,
  input logic                  io_sys_reset,
  spi_slave_responder_if.slave bus_io
);

  localparam int unsigned CntWidth = clog2(DATA_WIDTH);
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(DATA_WIDTH - 1);

  logic [2:0] sync_q, sync_rise, sync_fall;

  spi_sync_vec #(
    .Width  (3),
    .Stages (SYNC_STAGES)
  ) u_sync (
    .clk_i  (io_sys_clock),
    .rst_i  (io_sys_reset),
    .d_i    ({bus_io.io_spi_sclk, bus_io.io_spi_ss, bus_io.io_spi_mosi}),
    .q_o    (sync_q),
    .rise_o (sync_rise),
    .fall_o (sync_fall)
  );

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic sample_edge, shift_edge;
  logic unused_sync;

  assign sclk_rise   = sync_rise[2];
  assign sclk_fall   = sync_fall[2];
  assign ss_rise     = sync_rise[1];
  assign ss_fall     = sync_fall[1];
  assign mosi_s      = sync_q[0];
  assign unused_sync = ^{sync_q[2:1], sync_rise[0], sync_fall[0]};

  // Mode 0 samples on the leading (rising) edge and shifts on the trailing edge.
  assign sample_edge = (Cpol == Cpha) ? sclk_rise : sclk_fall;
  assign shift_edge  = (Cpol == Cpha) ? sclk_fall : sclk_rise;

  logic                  active_q, active_d;
  logic [CntWidth-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_payload_q, rx_payload_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  load;
  logic [DATA_WIDTH-1:0] rx_word;

  // Frame control, shift registers, RX stream and TX holding register next state.
  always_comb begin
    active_d     = active_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rx_valid_d   = rx_valid_q;
    rx_payload_d = rx_payload_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    overrun_d    = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;
    rx_word      = {rx_shift_q, mosi_s};

    if (rx_valid_q && bus_io.io_rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (ss_fall) begin
      active_d   = 1'b1;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      load       = 1'b1;
    end else if (ss_rise) begin
      // Any partial word is simply abandoned; the holding register is untouched.
      active_d  = 1'b0;
      bit_cnt_d = '0;
      miso_oe_d = 1'b0;
      miso_d    = 1'b0;
    end else if (active_q) begin
      if (sample_edge) begin
        rx_shift_d = rx_word[DATA_WIDTH-2:0];
        if (bit_cnt_q == LastBit) begin
          bit_cnt_d = '0;
          // A word consumed this very cycle frees the slot for the new one.
          if (!rx_valid_q || bus_io.io_rx_ready) begin
            rx_payload_d = rx_word;
            rx_valid_d   = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end else if (shift_edge) begin
        if (bit_cnt_q != '0) begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[DATA_WIDTH-2];
        end else begin
          load = 1'b1;
        end
      end
    end

    // Load sees the holding register as it was at the start of the cycle.
    if (load) begin
      miso_oe_d = 1'b1;
      if (hold_valid_q) begin
        tx_shift_d   = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_WORD;
        underrun_d = 1'b1;
      end
      miso_d = tx_shift_d[DATA_WIDTH-1];
    end

    if (bus_io.io_tx_valid && !hold_valid_q) begin
      hold_d       = bus_io.io_tx_payload;
      hold_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge io_sys_clock) begin
    if (io_sys_reset) begin
      active_q     <= 1'b0;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_payload_q <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      active_q     <= active_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rx_valid_q   <= rx_valid_d;
      rx_payload_q <= rx_payload_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus_io.io_spi_miso_write       = miso_q;
  assign bus_io.io_spi_miso_writeEnable = miso_oe_q;
  assign bus_io.io_rx_valid             = rx_valid_q;
  assign bus_io.io_rx_payload           = rx_payload_q;
  assign bus_io.io_tx_ready             = ~hold_valid_q;
  assign bus_io.io_active               = active_q;
  assign bus_io.io_overrun              = overrun_q;
  assign bus_io.io_underrun             = underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: drives an SPI master at f_sys/8 and compares
// against a word-level model of the TX holding register and RX stream.
module tb_spi_slave_responder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_responder_if #(.DATA_WIDTH(W)) bus ();

  spi_slave_responder #(
    .DATA_WIDTH  (W),
    .SYNC_STAGES (2),
    .IDLE_WORD   (8'hFF)
  ) dut (
    .io_sys_clock (clk),
    .io_sys_reset (rst),
    .bus_io       (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-level model.
  logic [7:0] m_hold;
  bit         m_hold_valid = 1'b0;
  bit         m_pend = 1'b0;
  logic [7:0] m_pend_word;
  int         m_underruns = 0, m_overruns = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] got_rx_q[$];
  int         seen_underruns = 0, seen_overruns = 0;

  task automatic model_load(output logic [7:0] word);
    if (m_hold_valid) begin
      word = m_hold;
      m_hold_valid = 1'b0;
    end else begin
      word = 8'hFF;
      m_underruns++;
    end
  endtask

  task automatic model_rx(input logic [7:0] word);
    if (m_pend) m_overruns++;
    else if (bus.io_rx_ready) exp_rx_q.push_back(word);
    else begin
      m_pend = 1'b1;
      m_pend_word = word;
    end
  endtask

  task automatic set_rx_ready(input logic v);
    bus.io_rx_ready = v;
    if (v && m_pend) begin
      exp_rx_q.push_back(m_pend_word);
      m_pend = 1'b0;
    end
  endtask

  // Pulses and RX handshakes as observed on the DUT.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.io_underrun) seen_underruns++;
      if (bus.io_overrun) seen_overruns++;
      if (bus.io_rx_valid && bus.io_rx_ready) got_rx_q.push_back(bus.io_rx_payload);
    end
  end

  task automatic check_scoreboard(input string tag);
    repeat (4) @(negedge clk);
    check_eq({tag, "_rx_count"}, 32'(got_rx_q.size()), 32'(exp_rx_q.size()));
    for (int i = 0; i < exp_rx_q.size() && i < got_rx_q.size(); i++)
      check_eq({tag, "_rx_word"}, 32'(got_rx_q[i]), 32'(exp_rx_q[i]));
    check_eq({tag, "_underruns"}, seen_underruns, m_underruns);
    check_eq({tag, "_overruns"}, seen_overruns, m_overruns);
    got_rx_q.delete();
    exp_rx_q.delete();
    seen_underruns = 0;
    seen_overruns  = 0;
    m_underruns    = 0;
    m_overruns     = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_valid"}, 32'(bus.io_rx_valid), 0);
    check_eq({tag, "_rx_payload"}, 32'(bus.io_rx_payload), 0);
    check_eq({tag, "_tx_ready"}, 32'(bus.io_tx_ready), 1);
    check_eq({tag, "_miso"}, 32'(bus.io_spi_miso_write), 0);
    check_eq({tag, "_miso_oe"}, 32'(bus.io_spi_miso_writeEnable), 0);
    check_eq({tag, "_active"}, 32'(bus.io_active), 0);
    check_eq({tag, "_overrun"}, 32'(bus.io_overrun), 0);
    check_eq({tag, "_underrun"}, 32'(bus.io_underrun), 0);
  endtask

  task automatic tx_push(input logic [7:0] w);
    check_eq("tx_ready", 32'(bus.io_tx_ready), 32'(!m_hold_valid));
    bus.io_tx_valid   = 1'b1;
    bus.io_tx_payload = w;
    if (!m_hold_valid) begin
      m_hold       = w;
      m_hold_valid = 1'b1;
    end
    @(negedge clk);
    bus.io_tx_valid = 1'b0;
  endtask

  // One SCLK period: 4 clocks low, 4 clocks high; MISO sampled just before the rise.
  task automatic send_bit(input logic mosi_bit, input bit do_push, input logic [7:0] push_word,
                          input bit chk_lat, output logic miso_bit);
    bus.io_spi_mosi = mosi_bit;
    if (do_push) begin
      tx_push(push_word);
      repeat (3) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    miso_bit = bus.io_spi_miso_write;
    bus.io_spi_sclk = 1'b1;
    if (chk_lat) begin
      repeat (2) @(negedge clk);
      check_eq("rx_valid_early", 32'(bus.io_rx_valid), 0);
      @(negedge clk);
      check_eq("rx_valid_latency", 32'(bus.io_rx_valid), 1);
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    bus.io_spi_sclk = 1'b0;
  endtask

  logic [7:0] fr_mosi[4];
  logic [7:0] fr_push[4];
  bit         fr_push_en[4];
  int         fr_n;
  int         fr_last_bits;
  bit         fr_chk_lat;

  task automatic clear_frame();
    for (int i = 0; i < 4; i++) begin
      fr_mosi[i]    = 8'($urandom);
      fr_push[i]    = 8'($urandom);
      fr_push_en[i] = 1'b0;
    end
    fr_n         = 1;
    fr_last_bits = 8;
    fr_chk_lat   = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    logic [7:0] exp_tx, got_tx;
    logic       b;
    int         nb;
    bus.io_spi_ss = 1'b0;
    model_load(exp_tx);
    repeat (6) @(negedge clk);
    check_eq({tag, "_miso_oe"}, 32'(bus.io_spi_miso_writeEnable), 1);
    check_eq({tag, "_active"}, 32'(bus.io_active), 1);
    for (int w = 0; w < fr_n; w++) begin
      nb = (w == fr_n - 1) ? fr_last_bits : 8;
      got_tx = '0;
      for (int i = 0; i < nb; i++) begin
        send_bit(fr_mosi[w][7-i], fr_push_en[w] && i == 2, fr_push[w],
                 fr_chk_lat && w == 0 && i == 7, b);
        got_tx[7-i] = b;
      end
      if (nb == 8) begin
        check_eq({tag, "_miso_word"}, 32'(got_tx), 32'(exp_tx));
        model_rx(fr_mosi[w]);
        model_load(exp_tx);
      end
    end
    repeat (5) @(negedge clk);
    bus.io_spi_ss = 1'b1;
    repeat (3) @(negedge clk);
    check_eq({tag, "_deselect_oe"}, 32'(bus.io_spi_miso_writeEnable), 0);
    check_eq({tag, "_deselect_miso"}, 32'(bus.io_spi_miso_write), 0);
    check_eq({tag, "_deselect_active"}, 32'(bus.io_active), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] dummy;
    logic       b;
    bus.io_spi_sclk   = 1'b0;
    bus.io_spi_ss     = 1'b1;
    bus.io_spi_mosi   = 1'b0;
    bus.io_rx_ready   = 1'b1;
    bus.io_tx_valid   = 1'b0;
    bus.io_tx_payload = '0;
    clear_frame();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("idle_active", 32'(bus.io_active), 0);

    // Preloaded 0xA5, master sends 0x3C; a refill keeps the word boundary fed.
    clear_frame();
    set_rx_ready(1'b0);
    tx_push(8'hA5);
    fr_mosi[0] = 8'h3C;
    fr_push_en[0] = 1'b1;
    fr_push[0] = 8'h5A;
    fr_chk_lat = 1'b1;
    run_frame("t1");
    check_eq("t1_rx_valid", 32'(bus.io_rx_valid), 1);
    check_eq("t1_rx_payload", 32'(bus.io_rx_payload), 32'h3C);
    set_rx_ready(1'b1);
    check_scoreboard("t1");

    // Empty TX at frame start, 0x11 arrives mid-word.
    clear_frame();
    fr_n = 2;
    fr_push_en[0] = 1'b1;
    fr_push[0] = 8'h11;
    run_frame("t2");
    check_scoreboard("t2");

    // Consumer stalled across two words.
    clear_frame();
    set_rx_ready(1'b0);
    fr_n = 2;
    fr_mosi[0] = 8'h01;
    fr_mosi[1] = 8'h02;
    run_frame("t3");
    check_eq("t3_rx_payload", 32'(bus.io_rx_payload), 32'h01);
    set_rx_ready(1'b1);
    check_scoreboard("t3");

    // Deselect after 5 bits, then a clean 0x7E frame.
    clear_frame();
    fr_last_bits = 5;
    run_frame("t4a");
    check_eq("t4_no_rx_valid", 32'(bus.io_rx_valid), 0);
    clear_frame();
    fr_mosi[0] = 8'h7E;
    run_frame("t4b");
    check_scoreboard("t4");

    // Reset in the middle of a word.
    clear_frame();
    bus.io_spi_ss = 1'b0;
    model_load(dummy);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0, 8'h00, 1'b0, b);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    rst = 1'b0;
    m_hold_valid = 1'b0;
    m_pend = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("t5_idle_active", 32'(bus.io_active), 0);
    bus.io_spi_ss = 1'b1;
    repeat (6) @(negedge clk);
    run_frame("t5b");
    check_scoreboard("t5");

    // Back-to-back 4-word burst with TX kept full.
    clear_frame();
    tx_push(8'($urandom));
    fr_n = 4;
    for (int i = 0; i < 4; i++) fr_push_en[i] = 1'b1;
    run_frame("t6");
    check_scoreboard("t6");

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      clear_frame();
      fr_n = int'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) fr_last_bits = int'($urandom_range(1, 7));
      for (int i = 0; i < 4; i++) fr_push_en[i] = 1'($urandom);
      if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
      set_rx_ready(1'($urandom));
      run_frame("rnd");
      set_rx_ready(1'b1);
      check_scoreboard("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
